c_skid_reg: RTL and testbench

//  Two-entry elastic register stage (skid buffer) with valid/ready handshake on both sides.

---
 rtl/c_skid_pkg.sv | 19 +
 rtl/c_skid_reg_if.sv | 25 ++
 rtl/c_dff.sv | 21 ++
 rtl/c_skid_reg.sv | 109 ++++++++++
 tb/tb_c_skid_reg.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/c_skid_pkg.sv
// Shared definitions for the two-entry skid register stage.
// The state encoding doubles as the occupancy count.
package c_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  function automatic logic holds_main(input skid_state_e s);
    return (s != EMPTY);
  endfunction

  function automatic logic holds_skid(input skid_state_e s);
    return (s == TWO);
  endfunction

endpackage

// File: rtl/c_skid_reg_if.sv
// Handshake bundle for c_skid_reg: producer side, consumer side, stage controls and occupancy.
// Handshake rule: a beat moves on a side exactly when valid and ready are both 1 at a rising clk edge.
interface c_skid_reg_if #(
  parameter int width = 32
);
  logic             active;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic [1:0]       occupancy;

  modport slave (
    input  active, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output active, flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/c_dff.sv
// Enabled data register with synchronous active-high reset to a fixed value.
module c_dff #(
  parameter int               width       = 32,
  parameter logic [width-1:0] reset_value = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= reset_value;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/c_skid_reg.sv
// Two-entry elastic register stage: full throughput with a registered in_ready,
// so consumer backpressure never reaches the producer combinationally.
module c_skid_reg
  import c_skid_pkg::*;
#(
  parameter int               width       = 32,
  parameter logic [width-1:0] reset_value = '0
) (
  input  logic          clk,
  input  logic          reset,
  c_skid_reg_if.slave   bus
);

  skid_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             main_v, skid_v;
  logic             push, pop;
  logic             main_en, skid_en, main_from_skid;
  logic [width-1:0] main_d, main_q, skid_q;

  assign main_v = holds_main(state_q);
  assign skid_v = holds_skid(state_q);

  assign bus.in_ready  = in_ready_q & bus.active & ~bus.flush;
  assign bus.out_valid = main_v & bus.active;
  assign bus.out_data  = main_v ? main_q : reset_value;
  assign bus.occupancy = state_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // While inactive nothing moves; flush wins over any same-cycle pop.
  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (bus.active) begin
      if (bus.flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (push) begin
              state_d = ONE;
              main_en = 1'b1;
            end
          end
          ONE: begin
            if (push && pop) begin
              main_en = 1'b1;
            end else if (push) begin
              state_d = TWO;
              skid_en = 1'b1;
            end else if (pop) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            if (pop) begin
              state_d        = ONE;
              main_en        = 1'b1;
              main_from_skid = 1'b1;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
      in_ready_d = (state_d != TWO);
    end
  end

  assign main_d = main_from_skid ? skid_q : bus.in_data;

  c_dff #(.width(width), .reset_value(reset_value)) u_main (
    .clk    (clk),
    .reset  (reset),
    .enable (main_en),
    .d      (main_d),
    .q      (main_q)
  );

  c_dff #(.width(width), .reset_value(reset_value)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .enable (skid_en),
    .d      (bus.in_data),
    .q      (skid_q)
  );

  a_no_push_in_two : assert property (@(posedge clk) disable iff (reset)
    !(push && state_q == TWO));
  a_occupancy : assert property (@(posedge clk) disable iff (reset)
    bus.occupancy == ({1'b0, main_v} + {1'b0, skid_v}));
  a_skid_implies_main : assert property (@(posedge clk) disable iff (reset)
    !skid_v || main_v);

endmodule

// File: tb/tb_c_skid_reg.sv
// Scoreboard bench for c_skid_reg: driver pushes accepted beats into exp_q,
// an independent monitor pops and compares on every output handshake.
module tb_c_skid_reg;

  localparam int               W  = 32;
  localparam logic [W-1:0]     RV = 32'hC0DE_0000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  c_skid_reg_if #(.width(W)) bus ();

  c_skid_reg #(.width(W), .reset_value(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; accepted beats are recorded before the rising edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r,
                       input logic a, input logic f);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.active    = a;
    bus.flush     = f;
    #1;
    if (!reset && bus.in_valid && bus.in_ready) exp_q.push_back(d);
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got beat 0x%0h expected no beat at %0t", bus.out_data, $time);
      end else begin
        chk("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.active    = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset for three cycles
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_occupancy", bus.occupancy, 0);
    chk("rst_out_data", bus.out_data, RV);

    // Streaming 0x1..0x10 back-to-back
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b1, 1'b0);
      chk("stream_in_ready", bus.in_ready, 1);
      if (i > 1) chk("stream_out_valid", bus.out_valid, 1);
    end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("stream_last_valid", bus.out_valid, 1);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("stream_drained_occ", bus.occupancy, 0);

    // Stall fills both entries
    drive(1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("stall_occupancy", bus.occupancy, 2);
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_first_out", bus.out_data, 32'hA);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("stall_second_valid", bus.out_valid, 1);
    chk("stall_second_out", bus.out_data, 32'hB);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("stall_empty_occ", bus.occupancy, 0);

    // active=0 while full: nothing moves
    drive(1'b1, 32'hD, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'hE, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hF, 1'b1, 1'b0, 1'b0);
      chk("idle_occupancy", bus.occupancy, 2);
      chk("idle_in_ready", bus.in_ready, 0);
      chk("idle_out_valid", bus.out_valid, 0);
    end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("resume_first", bus.out_data, 32'hD);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("resume_second", bus.out_data, 32'hE);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("resume_empty_occ", bus.occupancy, 0);

    // Flush in TWO with a same-cycle offer of 0xC
    drive(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h12, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b1, 1'b1);
    chk("flush_in_ready", bus.in_ready, 0);
    exp_q.delete();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("flush_occupancy", bus.occupancy, 0);
    chk("flush_in_ready_after", bus.in_ready, 1);
    chk("flush_out_valid", bus.out_valid, 0);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("flush_no_0xc", bus.out_valid, 0);

    // Reset with two beats in flight discards them
    drive(1'b1, 32'h21, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("midrst_occupancy", bus.occupancy, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, RV);

    // Random valid/ready, 50% each
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_occupancy", bus.occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
